pixel_recover_param: RTL and testbench
======================================

// Module: pixel_recover_param
// PURPOSE
// Parametrised successor of the camera pixel recovery stage. Samples the camera-side
// valid and frame_done strobes into the system clock domain and captures one pixel per
// valid rising edge. Emits raster hcount/vcount for a configurable frame geometry.
// Flags frame-geometry errors (short frame, overflow). Sits between camera capture
// and the frame buffer write port.
// PARAMETERS
// PIXEL_W      16   width of pixel_in/pixel_out
// H_ACTIVE     320  pixels per line; hcount wraps after H_ACTIVE-1
// V_ACTIVE     240  lines per frame
// HCOUNT_W     11   hcount_out width; must satisfy 2**HCOUNT_W > H_ACTIVE-1
// VCOUNT_W     10   vcount_out width; must satisfy 2**VCOUNT_W > V_ACTIVE-1
// SYNC_STAGES  2    flops per strobe synchroniser (>=2)
// PORTS
// system_clk_in    in   1         system clock (65 MHz); the only clock
// rst_n_in         in   1         reset, synchronous, active-low
// valid_pixel_in   in   1         camera-side pixel strobe; level held >= SYNC_STAGES+2 clks
// pixel_in         in   PIXEL_W   camera pixel; stable while valid_pixel_in high
// frame_done_in    in   1         camera-side end-of-frame strobe
// pixel_out        out  PIXEL_W   captured pixel
// data_valid_out   out  1         1-clk pulse: pixel_out/hcount_out/vcount_out valid
// hcount_out       out  HCOUNT_W  column of pixel_out
// vcount_out       out  VCOUNT_W  row of pixel_out
// frame_start_out  out  1         pulse coincident with data_valid_out for pixel (0,0)
// frame_end_out    out  1         1-clk pulse on each accepted frame_done edge
// short_frame_out  out  1         pulse with frame_end_out if fewer than H*V pixels seen
// overflow_out     out  1         sticky until next frame_end: pixel arrived after H*V
// BEHAVIOUR
// - Reset (rst_n_in==0 at clk edge): all outputs 0, counters 0, sync flops 0, state WAIT_SOF.
// - Each strobe passes SYNC_STAGES flops plus one history flop; edge = sync & ~hist.
// - pixel_in is registered on the cycle the valid edge is detected. data_valid_out and
//   pixel_out follow one cycle later. Latency from valid_pixel_in rise to data_valid_out:
//   SYNC_STAGES+2 clks.
// - States:
//   WAIT_SOF : valid edges dropped, no outputs. On frame_done edge -> ACTIVE.
//              No frame_end/short pulse is emitted on this first edge.
//   ACTIVE   : on valid edge, emit pixel at current (h,v). h==H_ACTIVE-1 -> h=0, v++.
//              After pixel (H-1,V-1) -> FULL.
//   FULL     : valid edges dropped; each sets overflow_out.
// - frame_done edge in ACTIVE or FULL:
//   - h,v <- 0; frame_end_out pulses; state -> ACTIVE.
//   - short_frame_out pulses if not FULL.
//   - overflow_out clears on the same cycle.
// - Simultaneous frame_done edge and valid edge: frame_done wins; the pixel is dropped.
// - Reset mid-frame returns to WAIT_SOF. The partial frame is discarded silently.
// - Counters never exceed H_ACTIVE-1 / V_ACTIVE-1. No width truncation occurs.
// CONFIGURATION
// - PIXEL_RECOVER_STATS_EN defined: adds outputs
//     frame_count_out [15:0] : wrapping count of frame_end pulses
//     last_pix_count_out [HCOUNT_W+VCOUNT_W-1:0] : pixels accepted in the last frame,
//       latched at frame_end; saturates at H*V.
//   Both reset to 0.
// - Undefined: these ports and their logic are absent. All other behaviour is identical.
// STRUCTURE
// - pixel_recover_pkg: state enum (WAIT_SOF, ACTIVE, FULL); localparam FRAME_PIX = H*V helper.
// - Sub-module strobe_sync_edge (SYNC_STAGES param): synchroniser + rising-edge pulse.
//   Instantiated twice (valid, frame_done).
// TESTING
// - Reset, 3 valid pulses, then frame_done: no data_valid_out, no frame_end_out
//   (WAIT_SOF discards).
// - H=4,V=2: frame_done, 8 pixels 0x0001..0x0008, frame_done:
//   8 data_valid_out with (h,v)=(0,0)..(3,1), frame_start on first, frame_end, no short.
// - H=4,V=2: frame_done, 5 pixels, frame_done:
//   frame_end_out and short_frame_out pulse together; next frame restarts at (0,0).
// - H=4,V=2: 10 pixels in a frame: 8 outputs, overflow_out rises on pixel 9,
//   clears at frame_end.
// - Valid edge and frame_done edge in the same cycle: no data_valid_out; counters 0.
// - Reset asserted at pixel (2,1): all outputs 0 next clk. Pixels ignored until the
//   next frame_done. STATS_EN build: frame_count_out=0.

Source files
------------

// File: rtl/pixel_recover_pkg.sv
// Shared types and helpers for the camera pixel recovery stage.
package pixel_recover_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_FULL     = 2'd2
    } state_e;

    // Number of pixels in one complete frame.
    function automatic int frame_pix(input int h_active, input int v_active);
        return h_active * v_active;
    endfunction

endpackage

// File: rtl/strobe_sync_edge.sv
// Multi-flop synchroniser for a camera-side strobe followed by rising-edge detection.
module strobe_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic system_clk_in,
    input  logic rst_n_in,
    input  logic strobe_s,
    output logic rise_s
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;

    // Synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge system_clk_in) begin
        if (!rst_n_in) begin
            sync_r <= '0;
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], strobe_s};
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise_s = sync_r[SYNC_STAGES-1] & ~hist_r;

endmodule

// File: rtl/pixel_recover_param.sv
// Camera pixel recovery: strobe sync, pixel capture, raster counting, frame checks.
// Optional PIXEL_RECOVER_STATS_EN adds frame and pixel-count statistics outputs.
module pixel_recover_param #(
    parameter int PIXEL_W     = 16,
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int HCOUNT_W    = 11,
    parameter int VCOUNT_W    = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         system_clk_in,
    input  logic                         rst_n_in,
    input  logic                         valid_pixel_in,
    input  logic [PIXEL_W-1:0]           pixel_in,
    input  logic                         frame_done_in,
    output logic [PIXEL_W-1:0]           pixel_out,
    output logic                         data_valid_out,
    output logic [HCOUNT_W-1:0]          hcount_out,
    output logic [VCOUNT_W-1:0]          vcount_out,
    output logic                         frame_start_out,
    output logic                         frame_end_out,
    output logic                         short_frame_out,
    output logic                         overflow_out
`ifdef PIXEL_RECOVER_STATS_EN
    ,
    output logic [15:0]                  frame_count_out,
    output logic [HCOUNT_W+VCOUNT_W-1:0] last_pix_count_out
`endif
);

    import pixel_recover_pkg::*;

    localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(H_ACTIVE - 1);
    localparam logic [VCOUNT_W-1:0] V_LAST = VCOUNT_W'(V_ACTIVE - 1);

    logic                valid_rise_s;
    logic                done_rise_s;
    state_e              state_r;
    logic [HCOUNT_W-1:0] h_r;
    logic [VCOUNT_W-1:0] v_r;
    logic [PIXEL_W-1:0]  cap_pix_r;
    logic [HCOUNT_W-1:0] cap_h_r;
    logic [VCOUNT_W-1:0] cap_v_r;
    logic                cap_vld_r;
    logic                cap_end_r;
    logic                cap_short_r;
    logic                ovf_r;

    strobe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_valid_sync (
        .system_clk_in (system_clk_in),
        .rst_n_in      (rst_n_in),
        .strobe_s      (valid_pixel_in),
        .rise_s        (valid_rise_s)
    );

    strobe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_done_sync (
        .system_clk_in (system_clk_in),
        .rst_n_in      (rst_n_in),
        .strobe_s      (frame_done_in),
        .rise_s        (done_rise_s)
    );

    // Frame FSM and capture stage; a frame_done edge takes priority over a pixel edge.
    always_ff @(posedge system_clk_in) begin
        if (!rst_n_in) begin
            state_r     <= ST_WAIT_SOF;
            h_r         <= '0;
            v_r         <= '0;
            cap_pix_r   <= '0;
            cap_h_r     <= '0;
            cap_v_r     <= '0;
            cap_vld_r   <= 1'b0;
            cap_end_r   <= 1'b0;
            cap_short_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            cap_vld_r   <= 1'b0;
            cap_end_r   <= 1'b0;
            cap_short_r <= 1'b0;
            if (done_rise_s) begin
                if (state_r != ST_WAIT_SOF) begin
                    cap_end_r   <= 1'b1;
                    cap_short_r <= (state_r != ST_FULL);
                end
                ovf_r   <= 1'b0;
                h_r     <= '0;
                v_r     <= '0;
                state_r <= ST_ACTIVE;
            end else if (valid_rise_s) begin
                case (state_r)
                    ST_ACTIVE: begin
                        cap_vld_r <= 1'b1;
                        cap_pix_r <= pixel_in;
                        cap_h_r   <= h_r;
                        cap_v_r   <= v_r;
                        if (h_r == H_LAST) begin
                            h_r <= '0;
                            if (v_r == V_LAST) begin
                                v_r     <= '0;
                                state_r <= ST_FULL;
                            end else begin
                                v_r <= v_r + VCOUNT_W'(1);
                            end
                        end else begin
                            h_r <= h_r + HCOUNT_W'(1);
                        end
                    end
                    ST_FULL: begin
                        ovf_r <= 1'b1;
                    end
                    default: begin
                        ovf_r <= ovf_r;
                    end
                endcase
            end
        end
    end

    // Output register stage.
    always_ff @(posedge system_clk_in) begin
        if (!rst_n_in) begin
            pixel_out       <= '0;
            data_valid_out  <= 1'b0;
            hcount_out      <= '0;
            vcount_out      <= '0;
            frame_start_out <= 1'b0;
            frame_end_out   <= 1'b0;
            short_frame_out <= 1'b0;
            overflow_out    <= 1'b0;
        end else begin
            pixel_out       <= cap_pix_r;
            data_valid_out  <= cap_vld_r;
            hcount_out      <= cap_h_r;
            vcount_out      <= cap_v_r;
            frame_start_out <= cap_vld_r && (cap_h_r == '0) && (cap_v_r == '0);
            frame_end_out   <= cap_end_r;
            short_frame_out <= cap_short_r;
            overflow_out    <= ovf_r;
        end
    end

`ifdef PIXEL_RECOVER_STATS_EN
    localparam int CNT_W     = HCOUNT_W + VCOUNT_W;
    localparam int FRAME_PIX = frame_pix(H_ACTIVE, V_ACTIVE);

    logic [CNT_W-1:0] pix_cnt_r;
    logic [CNT_W-1:0] last_cnt_r;
    logic [15:0]      frame_cnt_r;

    // Per-frame accepted-pixel counter, latched into the statistics on each frame end.
    always_ff @(posedge system_clk_in) begin
        if (!rst_n_in) begin
            pix_cnt_r   <= '0;
            last_cnt_r  <= '0;
            frame_cnt_r <= 16'd0;
        end else if (done_rise_s) begin
            if (state_r != ST_WAIT_SOF) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
                last_cnt_r  <= pix_cnt_r;
            end
            pix_cnt_r <= '0;
        end else if (valid_rise_s && (state_r == ST_ACTIVE) && (pix_cnt_r != CNT_W'(FRAME_PIX))) begin
            pix_cnt_r <= pix_cnt_r + CNT_W'(1);
        end
    end

    // Statistics output registers, aligned with frame_end_out.
    always_ff @(posedge system_clk_in) begin
        if (!rst_n_in) begin
            frame_count_out    <= 16'd0;
            last_pix_count_out <= '0;
        end else begin
            frame_count_out    <= frame_cnt_r;
            last_pix_count_out <= last_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_recover_param.sv
// Table-driven and randomized bench for pixel_recover_param with a small 4x2 frame.
module tb_pixel_recover_param;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int S  = 2;
    localparam int PW = 16;
    localparam int HW = 11;
    localparam int VW = 10;

    // kind: 0 = pixel, 1 = frame_done, 3 = pixel and frame_done together
    typedef struct {
        int          kind;
        logic [15:0] pix;
        bit          dv;
        int          h;
        int          v;
        bit          fs;
        bit          fe;
        bit          sh;
        bit          ov;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_pixel;
    logic [PW-1:0] pixel;
    logic          frame_done;
    logic [PW-1:0] pixel_out;
    logic          data_valid_out;
    logic [HW-1:0] hcount_out;
    logic [VW-1:0] vcount_out;
    logic          frame_start_out;
    logic          frame_end_out;
    logic          short_frame_out;
    logic          overflow_out;
`ifdef PIXEL_RECOVER_STATS_EN
    logic [15:0]      frame_count_out;
    logic [HW+VW-1:0] last_pix_count_out;
`endif

    int tests = 0;
    int fails = 0;

    int          dv_cnt = 0, fe_cnt = 0;
    logic [15:0] cap_pix;
    int          cap_h, cap_v;
    bit          cap_fs, cap_sh, cap_fe_ov;

    bit m_started;
    int m_n, m_fc, m_last;
    bit m_ovf;

    vec_t tbl[$];

    pixel_recover_param #(
        .PIXEL_W(PW), .H_ACTIVE(H), .V_ACTIVE(V),
        .HCOUNT_W(HW), .VCOUNT_W(VW), .SYNC_STAGES(S)
    ) dut (
        .system_clk_in   (clk),
        .rst_n_in        (rst_n),
        .valid_pixel_in  (valid_pixel),
        .pixel_in        (pixel),
        .frame_done_in   (frame_done),
        .pixel_out       (pixel_out),
        .data_valid_out  (data_valid_out),
        .hcount_out      (hcount_out),
        .vcount_out      (vcount_out),
        .frame_start_out (frame_start_out),
        .frame_end_out   (frame_end_out),
        .short_frame_out (short_frame_out),
        .overflow_out    (overflow_out)
`ifdef PIXEL_RECOVER_STATS_EN
        ,
        .frame_count_out    (frame_count_out),
        .last_pix_count_out (last_pix_count_out)
`endif
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (data_valid_out) begin
            dv_cnt  <= dv_cnt + 1;
            cap_pix <= pixel_out;
            cap_h   <= int'(hcount_out);
            cap_v   <= int'(vcount_out);
            cap_fs  <= frame_start_out;
        end
        if (frame_end_out) begin
            fe_cnt    <= fe_cnt + 1;
            cap_sh    <= short_frame_out;
            cap_fe_ov <= overflow_out;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic vec_t mk(input int kind, input int pix, input bit dv, input int h,
                                input int v, input bit fs, input bit fe, input bit sh, input bit ov);
        vec_t e;
        e.kind = kind; e.pix = 16'(pix); e.dv = dv; e.h = h; e.v = v;
        e.fs = fs; e.fe = fe; e.sh = sh; e.ov = ov;
        return e;
    endfunction

    // Frame-level reference: pixel index n maps to (n mod H, n div H) until H*V are seen.
    task automatic model_step(input int kind, input logic [15:0] pix, output vec_t e);
        e = mk(kind, int'(pix), 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (kind != 0) begin
            if (m_started) begin
                e.fe   = 1'b1;
                e.sh   = (m_n < H * V);
                m_fc   = m_fc + 1;
                m_last = m_n;
            end
            m_started = 1'b1;
            m_n       = 0;
            m_ovf     = 1'b0;
        end else if (m_started) begin
            if (m_n < H * V) begin
                e.dv = 1'b1;
                e.h  = m_n % H;
                e.v  = m_n / H;
                e.fs = (m_n == 0);
                m_n  = m_n + 1;
            end else begin
                m_ovf = 1'b1;
            end
        end
        e.ov = m_ovf;
    endtask

    task automatic model_reset();
        m_started = 1'b0; m_n = 0; m_fc = 0; m_last = 0; m_ovf = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; valid_pixel = 1'b0; frame_done = 1'b0; pixel = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_stats(input string tag);
`ifdef PIXEL_RECOVER_STATS_EN
        check({tag, "_frame_count"}, int'(frame_count_out), m_fc & 16'hFFFF);
        check({tag, "_last_pix_count"}, int'(last_pix_count_out), m_last);
`endif
    endtask

    // Drive one strobe event, then compare everything the monitor saw against e.
    task automatic apply_step(input vec_t e, input string tag);
        vec_t dummy;
        @(posedge clk); #1;
        dv_cnt = 0; fe_cnt = 0;
        pixel = e.pix;
        valid_pixel = (e.kind == 0 || e.kind == 3);
        frame_done  = (e.kind == 1 || e.kind == 3);
        repeat (5) @(posedge clk);
        #1 valid_pixel = 1'b0; frame_done = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        model_step(e.kind, e.pix, dummy);
        check({tag, "_dv_count"}, dv_cnt, int'(e.dv));
        if (e.dv) begin
            check({tag, "_pixel"}, int'(cap_pix), int'(e.pix));
            check({tag, "_hcount"}, cap_h, e.h);
            check({tag, "_vcount"}, cap_v, e.v);
            check({tag, "_frame_start"}, int'(cap_fs), int'(e.fs));
        end
        check({tag, "_fe_count"}, fe_cnt, int'(e.fe));
        if (e.fe) begin
            check({tag, "_short"}, int'(cap_sh), int'(e.sh));
            check({tag, "_ovf_at_end"}, int'(cap_fe_ov), 0);
            check_stats(tag);
        end
        check({tag, "_overflow"}, int'(overflow_out), int'(e.ov));
    endtask

    initial begin
        vec_t e;
        int   n;
        rst_n = 1'b0; valid_pixel = 1'b0; frame_done = 1'b0; pixel = '0;
        do_reset();

        check("reset_dv", int'(data_valid_out), 0);
        check("reset_fe", int'(frame_end_out), 0);
        check("reset_ovf", int'(overflow_out), 0);
        check("reset_hcount", int'(hcount_out), 0);
        check_stats("reset");

        // Directed table: WAIT_SOF drop, full frame, short frame, overflow frame.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 16'h0011 + i, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 1 + i, 1, i % 4, i / 4, i == 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 16'h0021 + i, 1, i % 4, i / 4, i == 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 16'h0031 + i, 1, i % 4, i / 4, i == 0, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0039, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 16'h003A, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
        foreach (tbl[i]) apply_step(tbl[i], $sformatf("tbl%0d", i));

        // Latency from valid rise to data_valid_out.
        @(posedge clk); #1;
        pixel = 16'hBEEF; valid_pixel = 1'b1;
        n = 0;
        while (n < 20 && !data_valid_out) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, S + 2);
        check("latency_hcount", int'(hcount_out), 0);
        model_step(0, 16'hBEEF, e);
        repeat (3) @(posedge clk);
        #1 valid_pixel = 1'b0;
        repeat (6) @(posedge clk);

        // Pixel and frame_done edges in the same cycle: frame_done wins.
        apply_step(mk(3, 16'h0C0C, 0, 0, 0, 0, 1, 1, 0), "simul");
        apply_step(mk(0, 16'h0D0D, 1, 0, 0, 1, 0, 0, 0), "after_simul");

        // Reset while pixel (2,1) is on the outputs.
        for (int i = 1; i < 6; i++) apply_step(mk(0, 16'h0E00 + i, 1, i % 4, i / 4, 0, 0, 0, 0), "pre_rst");
        @(posedge clk); #1;
        pixel = 16'h0E06; valid_pixel = 1'b1;
        n = 0;
        while (n < 20 && !data_valid_out) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_pix_h", int'(hcount_out), 2);
        check("rst_pix_v", int'(vcount_out), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_dv", int'(data_valid_out), 0);
        check("midrst_pixel", int'(pixel_out), 0);
        check("midrst_hcount", int'(hcount_out), 0);
        check("midrst_vcount", int'(vcount_out), 0);
        valid_pixel = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        check_stats("midrst");
        apply_step(mk(0, 16'h0F01, 0, 0, 0, 0, 0, 0, 0), "post_rst_drop");
        apply_step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_sof");
        apply_step(mk(0, 16'h0F02, 1, 0, 0, 1, 0, 0, 0), "post_rst_first");

        // Randomized traffic against the frame-level model.
        do_reset();
        for (int i = 0; i < 150; i++) begin
            int          r;
            logic [15:0] p;
            r = int'($urandom_range(0, 99));
            p = 16'($urandom_range(0, 65535));
            model_step_preview(r < 10 ? 1 : (r < 12 ? 3 : 0), p, e);
            apply_step(e, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Expected outputs for the next step without advancing the model (apply_step advances it).
    task automatic model_step_preview(input int kind, input logic [15:0] pix, output vec_t e);
        bit s_started, s_ovf;
        int s_n, s_fc, s_last;
        s_started = m_started; s_ovf = m_ovf; s_n = m_n; s_fc = m_fc; s_last = m_last;
        model_step(kind, pix, e);
        m_started = s_started; m_ovf = s_ovf; m_n = s_n; m_fc = s_fc; m_last = s_last;
    endtask

endmodule
